// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// Signal names keep the pipeline's _i/_o naming so they line up with the ID/EX wiring.
interface ex_div_if;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        busy_o;
   logic        ready_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        reg_wen_o;

   modport master (
      output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
      input  busy_o, ready_o, result_o, rd_addr_o, reg_wen_o
   );
   modport slave (
      input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
      output busy_o, ready_o, result_o, rd_addr_o, reg_wen_o
   );
endinterface

// File: rtl/ex_div.sv
// 32-bit restoring divider for the EX stage: DIV/DIVU/REM/REMU, 32 iterations plus
// one sign-fix cycle; divide-by-zero and signed overflow skip straight to the fix cycle.
module ex_div (
   input logic     clk,
   input logic     rstn,
   ex_div_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, nxt;
   logic [5:0]  cnt;
   logic [31:0] quo, rem, dvs;
   logic        is_rem, neg_q, neg_r, bypass;
   logic [4:0]  rd_r;
   logic        ready_r;
   logic [31:0] result_r;
   logic [4:0]  rd_out_r;

   logic        accept, signed_op, div0, ovf;
   logic [31:0] a_abs, b_abs, special, fix_res;
   logic [32:0] shifted;
   logic        ge;

   assign signed_op = ~bus.op_i[0];
   assign accept    = (state == IDLE) && bus.start_i && !bus.flush_i;
   assign div0      = (bus.divisor_i == 32'd0);
   assign ovf       = signed_op && (bus.dividend_i == 32'h8000_0000) &&
                      (bus.divisor_i == 32'hFFFF_FFFF);
   assign a_abs     = (signed_op && bus.dividend_i[31]) ? -bus.dividend_i : bus.dividend_i;
   assign b_abs     = (signed_op && bus.divisor_i[31])  ? -bus.divisor_i  : bus.divisor_i;
   assign special   = div0 ? (bus.op_i[1] ? bus.dividend_i : 32'hFFFF_FFFF)
                           : (bus.op_i[1] ? 32'd0 : 32'h8000_0000);

   // Partial remainder is always < divisor, so the shifted value fits 33 bits and the
   // 32-bit subtraction below is exact whenever ge is set.
   assign shifted   = {rem, quo[31]};
   assign ge        = shifted[32] || (shifted[31:0] >= dvs);

   assign fix_res   = bypass ? quo :
                      is_rem ? (neg_r ? -rem : rem) :
                               (neg_q ? -quo : quo);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (bus.flush_i) nxt = IDLE;
      else begin
         case (state)
            IDLE: if (bus.start_i) nxt = (div0 || ovf) ? FIX : CALC;
            CALC: if (cnt == 6'd31) nxt = FIX;
            FIX:  nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy_o    = (state != IDLE);
      bus.ready_o   = ready_r;
      bus.reg_wen_o = ready_r;
      bus.result_o  = result_r;
      bus.rd_addr_o = rd_out_r;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt    <= 6'd0;
         quo    <= 32'd0;
         rem    <= 32'd0;
         dvs    <= 32'd0;
         is_rem <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         bypass <= 1'b0;
         rd_r   <= 5'd0;
      end else if (accept) begin
         cnt    <= 6'd0;
         quo    <= (div0 || ovf) ? special : a_abs;
         rem    <= 32'd0;
         dvs    <= b_abs;
         is_rem <= bus.op_i[1];
         neg_q  <= signed_op && (bus.dividend_i[31] ^ bus.divisor_i[31]);
         neg_r  <= signed_op && bus.dividend_i[31];
         bypass <= div0 || ovf;
         rd_r   <= bus.rd_addr_i;
      end else if (state == CALC) begin
         cnt <= cnt + 6'd1;
         quo <= {quo[30:0], ge};
         rem <= ge ? (shifted[31:0] - dvs) : shifted[31:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ready_r  <= 1'b0;
         result_r <= 32'd0;
         rd_out_r <= 5'd0;
      end else begin
         ready_r <= (state == FIX) && !bus.flush_i;
         if ((state == FIX) && !bus.flush_i) begin
            result_r <= fix_res;
            rd_out_r <= rd_r;
         end
      end
   end
endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: stimulus pushes expected results with their due cycle,
// a negedge monitor pops and checks every ready pulse.
module tb_ex_div;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          due;
   } exp_t;
   exp_t q[$];

   ex_div_if bus();
   ex_div dut (.clk(clk), .rstn(rstn), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn === 1'b1 && bus.ready_o === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", bus.result_o, e.res);
            chk("rd_addr", {27'd0, bus.rd_addr_o}, {27'd0, e.rd});
            chk("reg_wen", {31'd0, bus.reg_wen_o}, 32'd1);
            chk("ready_cycle", cyc, e.due);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input bit track);
      exp_t e;
      bus.op_i       = op;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      bus.rd_addr_i  = rd;
      bus.start_i    = 1'b1;
      if (track) begin
         e.res = exp; e.rd = rd; e.due = cyc + lat;
         q.push_back(e);
      end
      tick();
      bus.start_i = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 60; i++) begin
         if (q.size() == 0) break;
         tick();
      end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, input int lat);
      issue(op, a, b, rd, exp, lat, 1'b1);
      drain();
   endtask

   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   initial begin
      bit busy_ok;
      bus.start_i = 0; bus.op_i = 0; bus.dividend_i = 0; bus.divisor_i = 0;
      bus.rd_addr_i = 0; bus.flush_i = 0;
      #3;
      chk("rst_busy",   {31'd0, bus.busy_o},    32'd0);
      chk("rst_ready",  {31'd0, bus.ready_o},   32'd0);
      chk("rst_result", bus.result_o,           32'd0);
      chk("rst_rd",     {27'd0, bus.rd_addr_o}, 32'd0);
      repeat (3) tick();
      rstn = 1'b1;

      // DIVU 100/7 with busy window check and an ignored start mid-operation
      issue(DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34, 1'b1);
      busy_ok = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
         if (i == 5) begin
            bus.op_i = DIV; bus.dividend_i = 32'd9; bus.divisor_i = 32'd3;
            bus.rd_addr_i = 5'd9; bus.start_i = 1'b1;
         end else bus.start_i = 1'b0;
         tick();
      end
      chk("busy_window", {31'd0, busy_ok}, 32'd1);
      chk("busy_c34", {31'd0, bus.busy_o}, 32'd0);
      drain();

      run(REM,  32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 34);
      run(DIV,  32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 34);
      run(DIV,  32'hFFFF_FF9C, 32'd7, 5'd3, 32'hFFFF_FFF2, 34);
      run(REM,  32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFFE, 34);
      run(DIV,  32'd100, 32'hFFFF_FFF9, 5'd6, 32'hFFFF_FFF2, 34);
      run(REM,  32'd100, 32'hFFFF_FFF9, 5'd7, 32'd2, 34);
      run(REMU, 32'd100, 32'd7, 5'd8, 32'd2, 34);
      run(DIVU, 32'hFFFF_FFFF, 32'd1, 5'd10, 32'hFFFF_FFFF, 34);
      run(DIVU, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'h7FFF_FFFC, 34);

      // divide by zero and signed overflow bypass
      issue(DIVU, 32'd55, 32'd0, 5'd12, 32'hFFFF_FFFF, 2, 1'b1);
      chk("div0_busy_c1", {31'd0, bus.busy_o}, 32'd1);
      drain();
      run(REMU, 32'h1234, 32'd0, 5'd13, 32'h1234, 2);
      run(DIV,  32'hFFFF_FFFB, 32'd0, 5'd14, 32'hFFFF_FFFF, 2);
      run(REM,  32'hFFFF_FFFB, 32'd0, 5'd15, 32'hFFFF_FFFB, 2);
      run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2);
      run(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 2);

      // flush at cycle 10 of a DIVU
      issue(DIVU, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 1'b0);
      repeat (9) tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      chk("flush_busy", {31'd0, bus.busy_o}, 32'd0);
      repeat (40) tick();
      run(DIVU, 32'd1000, 32'd10, 5'd21, 32'd100, 34);

      // flush and start together in IDLE: start dropped
      bus.flush_i = 1'b1;
      issue(DIVU, 32'd8, 32'd2, 5'd22, 32'd0, 0, 1'b0);
      bus.flush_i = 1'b0;
      chk("flush_wins", {31'd0, bus.busy_o}, 32'd0);
      repeat (40) tick();

      // reset at cycle 15 of an operation
      issue(DIVU, 32'd77, 32'd7, 5'd23, 32'd0, 0, 1'b0);
      repeat (14) tick();
      rstn = 1'b0;
      #1;
      chk("mid_rst_busy",   {31'd0, bus.busy_o},    32'd0);
      chk("mid_rst_ready",  {31'd0, bus.ready_o},   32'd0);
      chk("mid_rst_wen",    {31'd0, bus.reg_wen_o}, 32'd0);
      chk("mid_rst_result", bus.result_o,           32'd0);
      chk("mid_rst_rd",     {27'd0, bus.rd_addr_o}, 32'd0);
      repeat (2) tick();
      rstn = 1'b1;
      repeat (40) tick();

      // back-to-back: second start issued in the ready cycle of the first
      issue(DIVU, 32'd81, 32'd9, 5'd24, 32'd9, 34, 1'b1);
      repeat (33) tick();
      chk("b2b_ready", {31'd0, bus.ready_o}, 32'd1);
      issue(REMU, 32'd81, 32'd10, 5'd25, 32'd1, 34, 1'b1);
      drain();
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous and active-low.
REQ-004 start_i  input  1  divide request from the EX decode of the ID/EX register outputs.
REQ-005 op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 dividend_i  input  32  op1 from the ID/EX stage.
REQ-007 divisor_i  input  32  op2 from the ID/EX stage.
REQ-008 rd_addr_i  input  5  destination register.
REQ-009 flush_i  input  1  jump/flush from ctrl; aborts any operation in progress.
REQ-010 busy_o  output  1  hold request to ctrl; drives the pipeline hold_flag.
REQ-011 ready_o  output  1  one-cycle result-valid pulse.
REQ-012 result_o  output  32  quotient or remainder.
REQ-013 rd_addr_o  output  5  destination register for result_o.
REQ-014 reg_wen_o  output  1  register-file write enable; SHALL equal ready_o at all times.

Function
REQ-015 FSM states SHALL be IDLE, CALC and FIX, all registered; busy_o SHALL be 1 exactly when state != IDLE.
REQ-016 In IDLE, start_i=1 with flush_i=0 SHALL be accepted at that clock edge; op_i and rd_addr_i SHALL be latched there.
REQ-017 start_i SHALL be ignored in any state other than IDLE.
REQ-018 Normal accept: the block SHALL load |dividend| and |divisor| into its working registers and enter CALC with the iteration counter at 0.
- DIVU/REMU use raw unsigned values.
- DIV/REM use two's-complement magnitudes.
REQ-019 CALC SHALL run one restoring shift-subtract iteration per cycle for exactly 32 cycles, then go to FIX.
REQ-020 FIX SHALL apply sign correction and register the results, then return to IDLE.
- Quotient is negated when sign(dividend) XOR sign(divisor) = 1 (signed ops only).
- Remainder takes the sign of the dividend.
REQ-021 Latency: with start accepted at the end of cycle 0, busy_o SHALL be 1 in cycles 1..33 and ready_o=1 in cycle 34 only.
REQ-022 Divide by zero (divisor_i=0) SHALL bypass CALC and go straight to FIX.
- DIV/DIVU result: 0xFFFFFFFF.
- REM/REMU result: dividend_i.
- busy_o=1 in cycle 1, ready_o=1 in cycle 2.
REQ-023 Signed overflow (DIV/REM with dividend 0x80000000, divisor 0xFFFFFFFF) SHALL bypass CALC like REQ-022.
- DIV result: 0x80000000.
- REM result: 0.
- Same cycle timing as REQ-022.
REQ-024 result_o and rd_addr_o SHALL hold their last values when ready_o=0.
REQ-025 A new start_i SHALL be accepted in the same cycle ready_o is 1, allowing back-to-back operation.
REQ-026 flush_i=1 in any state SHALL force IDLE at the next edge.
- No ready_o pulse for the aborted operation.
- busy_o=0 from the next cycle.
- If flush_i and start_i are both 1 in IDLE, flush SHALL win and start is dropped.
REQ-027 The iteration counter SHALL be 6 bits, cleared on entry to CALC, and SHALL never wrap while in CALC.

Reset
REQ-028 While rstn=0, independent of clk:
- state SHALL be IDLE and the counter 0.
- busy_o, ready_o and reg_wen_o SHALL be 0.
- result_o SHALL be 0 and rd_addr_o 5'd0.
REQ-029 Reset asserted mid-operation SHALL discard the operation; no ready_o pulse SHALL follow the deassertion of rstn.
REQ-030 After rstn rises, the first start_i SHALL be accepted at the first clock edge.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- DIVU 100/7, rd=5, start at cycle 0 -> busy_o 1..33; cycle 34: ready_o=1, result_o=14, rd_addr_o=5, reg_wen_o=1.
- REM 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFF at cycle 34; DIV on the same operands -> 0xFFFFFFFD (-3).
- DIVU x/0 -> result_o=0xFFFFFFFF at cycle 2; REMU 0x1234/0 -> result_o=0x1234 at cycle 2.
- DIV 0x80000000/0xFFFFFFFF -> result_o=0x80000000 at cycle 2; REM on the same operands -> 0.
- flush_i pulsed at cycle 10 of a DIVU -> busy_o=0 from cycle 11, no ready_o pulse, next start accepted normally.
- rstn low at cycle 15 for 2 cycles -> all outputs 0 immediately, no ready_o afterwards; a back-to-back start in the ready_o cycle completes 34 cycles later.
